reg_write_back_queue: RTL

REG_WRITE_BACK_QUEUE -- requirements
Module: reg_write_back_queue

---
 rtl/reg_write_back_queue_if.sv | 34 +++
 rtl/reg_write_back_queue.sv | 82 ++++++++
 2 files changed

// File: rtl/reg_write_back_queue_if.sv
// Bundle of write-back, register-file and lookup signals around reg_write_back_queue.
// WB_flag/WB_accept and REG_write_flag/REG_ready are valid/ready pairs: a transfer
// happens on a rising edge where both are 1; valid never waits on ready.
interface reg_write_back_queue_if #(
    parameter int DEPTH = 4,
    parameter int CW    = 8,
    parameter int DW    = 32
);
    logic                       WB_flag;
    logic [CW-1:0]              WB_code;
    logic [DW-1:0]              WB_data;
    logic                       WB_accept;
    logic                       REG_write_flag;
    logic [CW-1:0]              REG_write_code;
    logic [DW-1:0]              REG_write_data;
    logic                       REG_ready;
    logic [CW-1:0]              LOOKUP_code;
    logic                       LOOKUP_hit;
    logic [DW-1:0]              LOOKUP_data;
    logic [$clog2(DEPTH):0]     COUNT;
    logic                       OVERFLOW;

    modport master (
        output WB_flag, WB_code, WB_data, REG_ready, LOOKUP_code,
        input  WB_accept, REG_write_flag, REG_write_code, REG_write_data,
        input  LOOKUP_hit, LOOKUP_data, COUNT, OVERFLOW
    );

    modport slave (
        input  WB_flag, WB_code, WB_data, REG_ready, LOOKUP_code,
        output WB_accept, REG_write_flag, REG_write_code, REG_write_data,
        output LOOKUP_hit, LOOKUP_data, COUNT, OVERFLOW
    );
endinterface

// File: rtl/reg_write_back_queue.sv
// Circular write-back queue feeding the register file, with a youngest-match
// lookup so readers can forward values that are still waiting to be written.
module reg_write_back_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 8,
    parameter int DW    = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    reg_write_back_queue_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [CW-1:0]   code_mem [DEPTH];
    logic [DW-1:0]   data_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            overflow;

    logic            not_empty;
    logic            accept;
    logic            push;
    logic            pop;

    assign not_empty = (count != '0);
    // A pop on the same edge frees the slot, so a full queue can still accept.
    assign accept    = (count < CNTW'(DEPTH)) || bus.REG_ready;
    assign push      = bus.WB_flag && accept;
    assign pop       = not_empty && bus.REG_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (bus.WB_flag && !accept) overflow <= 1'b1;
        end
    end

    // Storage is not reset; only occupied slots are ever observed.
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            code_mem[wr_ptr] <= bus.WB_code;
            data_mem[wr_ptr] <= bus.WB_data;
        end
    end

    logic [AW-1:0] slot;
    logic          lookup_hit;
    logic [DW-1:0] lookup_data;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        slot        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + AW'(i);
            if ((CNTW'(i) < count) && (code_mem[slot] == bus.LOOKUP_code)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_mem[slot];
            end
        end
    end

    assign bus.WB_accept      = accept;
    assign bus.REG_write_flag = not_empty;
    assign bus.REG_write_code = not_empty ? code_mem[rd_ptr] : '0;
    assign bus.REG_write_data = not_empty ? data_mem[rd_ptr] : '0;
    assign bus.LOOKUP_hit     = lookup_hit;
    assign bus.LOOKUP_data    = lookup_data;
    assign bus.COUNT          = count;
    assign bus.OVERFLOW       = overflow;
endmodule
